// File: rtl/decryption_regfile_arbiter.sv
// Round-robin arbiter that shares the decryption key register-file access
// port between the host config bus (req0) and the boot-time key loader (req1).
//
// Handshake: a requester raises reqN_valid with its command and holds it
// until reqN_ack. The ack is a single-cycle pulse, and reqN_rdata/reqN_error
// are valid with it and hold until that requester's next ack. The regfile
// side sees a one-cycle rf_read or rf_write strobe and answers with rf_done
// (plus rf_error) in any later WAIT cycle. Only one transaction is in flight.
module decryption_regfile_arbiter #(
    parameter int addr_width     = 8,
    parameter int reg_width      = 16,
    parameter int timeout_cycles = 15,
    parameter int tmo_width      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // requester 0: host config bus
    input  logic                  req0_valid,
    input  logic                  req0_write,
    input  logic [addr_width-1:0] req0_addr,
    input  logic [reg_width-1:0]  req0_wdata,
    output logic                  req0_ack,
    output logic [reg_width-1:0]  req0_rdata,
    output logic                  req0_error,
    // requester 1: boot-time key loader
    input  logic                  req1_valid,
    input  logic                  req1_write,
    input  logic [addr_width-1:0] req1_addr,
    input  logic [reg_width-1:0]  req1_wdata,
    output logic                  req1_ack,
    output logic [reg_width-1:0]  req1_rdata,
    output logic                  req1_error,
    // register-file access port
    output logic [addr_width-1:0] rf_addr,
    output logic                  rf_read,
    output logic                  rf_write,
    output logic [reg_width-1:0]  rf_wdata,
    input  logic [reg_width-1:0]  rf_rdata,
    input  logic                  rf_done,
    input  logic                  rf_error,
    // status
    output logic                  busy,
    output logic [1:0]            grant
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [addr_width-1:0] r_rf_addr;
    logic [reg_width-1:0]  r_rf_wdata;
    logic                  r_rf_read;
    logic                  r_rf_write;
    logic                  r_is_write;
    logic [1:0]            r_grant;
    logic [tmo_width-1:0]  r_cnt;
    logic                  r_last1;      // 1 when req1 was served last
    logic [reg_width-1:0]  r_resp_data;
    logic                  r_resp_err;
    logic                  r_ack0;
    logic                  r_ack1;
    logic [reg_width-1:0]  r_rdata0;
    logic [reg_width-1:0]  r_rdata1;
    logic                  r_err0;
    logic                  r_err1;

    // A requester is masked during its own ack cycle: its valid is still
    // legitimately high there and must not be mistaken for a new request.
    logic                  w_v0;
    logic                  w_v1;
    logic                  w_any;
    logic                  w_pick1;
    logic                  w_timeout;

    assign w_v0      = req0_valid & ~r_ack0;
    assign w_v1      = req1_valid & ~r_ack1;
    assign w_any     = w_v0 | w_v1;
    assign w_pick1   = w_v1 & (~w_v0 | ~r_last1);
    assign w_timeout = (r_cnt == tmo_width'(timeout_cycles - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: grant, wait for done or timeout, one response cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_any) w_next = S_WAIT;
            S_WAIT: if (rf_done || w_timeout) w_next = S_RESP;
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: latch the winning command, time the wait, route the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_addr   <= '0;
            r_rf_wdata  <= '0;
            r_rf_read   <= 1'b0;
            r_rf_write  <= 1'b0;
            r_is_write  <= 1'b0;
            r_grant     <= 2'b00;
            r_cnt       <= '0;
            r_last1     <= 1'b1;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
            r_err0      <= 1'b0;
            r_err1      <= 1'b0;
        end else begin
            // Strobes and acks are single-cycle pulses by default.
            r_rf_read  <= 1'b0;
            r_rf_write <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant    <= w_pick1 ? 2'b10 : 2'b01;
                        r_rf_addr  <= w_pick1 ? req1_addr  : req0_addr;
                        r_rf_wdata <= w_pick1 ? req1_wdata : req0_wdata;
                        r_is_write <= w_pick1 ? req1_write : req0_write;
                        r_rf_write <= w_pick1 ? req1_write : req0_write;
                        r_rf_read  <= w_pick1 ? ~req1_write : ~req0_write;
                        r_cnt      <= '0;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (rf_done) begin
                        r_resp_err  <= rf_error;
                        r_resp_data <= r_is_write ? '0 : rf_rdata;
                    end else if (w_timeout) begin
                        r_resp_err  <= 1'b1;
                        r_resp_data <= '0;
                    end
                end
                S_RESP: begin
                    if (r_grant[1]) begin
                        r_ack1   <= 1'b1;
                        r_rdata1 <= r_resp_data;
                        r_err1   <= r_resp_err;
                    end else begin
                        r_ack0   <= 1'b1;
                        r_rdata0 <= r_resp_data;
                        r_err0   <= r_resp_err;
                    end
                    r_last1 <= r_grant[1];
                    r_cnt   <= '0;
                    r_grant <= 2'b00;
                end
                default: begin
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

    assign rf_addr    = r_rf_addr;
    assign rf_wdata   = r_rf_wdata;
    assign rf_read    = r_rf_read;
    assign rf_write   = r_rf_write;
    assign grant      = r_grant;
    assign busy       = (r_state != S_IDLE);
    assign req0_ack   = r_ack0;
    assign req0_rdata = r_rdata0;
    assign req0_error = r_err0;
    assign req1_ack   = r_ack1;
    assign req1_rdata = r_rdata1;
    assign req1_error = r_err1;

endmodule

// File: tb/tb_decryption_regfile_arbiter.sv
// Directed bench for decryption_regfile_arbiter with a small regfile stub
// (key registers at 0x10..0x17, everything else is an invalid address).
module tb_decryption_regfile_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_write, req0_ack, req0_error;
    logic [7:0]  req0_addr;
    logic [15:0] req0_wdata, req0_rdata;
    logic        req1_valid, req1_write, req1_ack, req1_error;
    logic [7:0]  req1_addr;
    logic [15:0] req1_wdata, req1_rdata;
    logic [7:0]  rf_addr;
    logic        rf_read, rf_write, rf_done, rf_error;
    logic [15:0] rf_wdata, rf_rdata;
    logic        busy;
    logic [1:0]  grant;

    // stub controls
    logic        stub_en;
    logic        force_done;
    logic        force_err;
    logic [15:0] mem [0:255];
    logic        addr_ok;

    int checks = 0;
    int errors = 0;

    // monitor totals
    int         wcnt = 0, rcnt = 0, bothcnt = 0, bcnt = 0, a0cnt = 0, a1cnt = 0;
    logic [7:0] strobe_addr = 8'h00;
    logic [1:0] strobe_grant = 2'b00;
    int         s_w, s_r, s_b, s_a0, s_a1;
    int         cyc;

    decryption_regfile_arbiter #(
        .addr_width(8), .reg_width(16), .timeout_cycles(15), .tmo_width(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ack(req0_ack), .req0_rdata(req0_rdata),
        .req0_error(req0_error),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ack(req1_ack), .req1_rdata(req1_rdata),
        .req1_error(req1_error),
        .rf_addr(rf_addr), .rf_read(rf_read), .rf_write(rf_write),
        .rf_wdata(rf_wdata), .rf_rdata(rf_rdata), .rf_done(rf_done),
        .rf_error(rf_error), .busy(busy), .grant(grant)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // regfile stub: zero-wait when enabled, silent when not
    assign addr_ok = (rf_addr[7:3] == 5'b00010);
    always_comb begin
        rf_done  = (stub_en & (rf_read | rf_write)) | force_done;
        rf_error = rf_done & (force_err | ~addr_ok);
        rf_rdata = force_done ? 16'hBEEF : ((rf_read & addr_ok) ? mem[rf_addr] : 16'h0000);
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
        end else if (rf_write && stub_en && addr_ok) begin
            mem[rf_addr] <= rf_wdata;
        end
    end

    // monitor at the falling edge
    always @(negedge clk) begin
        if (rf_write) wcnt++;
        if (rf_read) rcnt++;
        if (rf_read && rf_write) bothcnt++;
        if (busy) bcnt++;
        if (req0_ack) a0cnt++;
        if (req1_ack) a1cnt++;
        if (rf_read || rf_write) begin
            strobe_addr  = rf_addr;
            strobe_grant = grant;
        end
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // advance to just after the next falling edge
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic snap();
        s_w  = wcnt;
        s_r  = rcnt;
        s_b  = bcnt;
        s_a0 = a0cnt;
        s_a1 = a1cnt;
    endtask

    task automatic drive0(input logic v, input logic w, input logic [7:0] a, input logic [15:0] d);
        req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
    endtask

    task automatic drive1(input logic v, input logic w, input logic [7:0] a, input logic [15:0] d);
        req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
    endtask

    // cycles from request to ack, bounded by max_cyc
    task automatic wait_ack(input int who, input int max_cyc, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!((who == 0) ? req0_ack : req1_ack) && n < max_cyc);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        stub_en = 1'b1; force_done = 1'b0; force_err = 1'b0;
        drive0(1'b0, 1'b0, 8'h00, 16'h0000);
        drive1(1'b0, 1'b0, 8'h00, 16'h0000);
        step();
        step();

        // reset state
        check("rst_ctrl", {req0_ack, req1_ack, req0_error, req1_error, busy, grant, rf_read, rf_write}, 0);
        check("rst_rf_addr", rf_addr, 8'h00);
        check("rst_rdata", {req0_rdata, req1_rdata}, 0);
        rst_n = 1'b1;
        step();

        // 1: req0 write caesar key
        snap();
        drive0(1'b1, 1'b1, 8'h10, 16'h0003);
        wait_ack(0, 40, cyc);
        drive0(1'b0, 1'b0, 8'h00, 16'h0000);
        check("t1_latency", cyc, 3);
        check("t1_wstrobe", wcnt - s_w, 1);
        check("t1_rstrobe", rcnt - s_r, 0);
        check("t1_rf_addr", strobe_addr, 8'h10);
        check("t1_grant", strobe_grant, 2'b01);
        check("t1_error", req0_error, 1'b0);
        check("t1_caesar_key", mem[8'h10], 16'h0003);
        check("t1_busy_cycles", bcnt - s_b, 2);
        step();
        check("t1_ack_pulse", req0_ack, 1'b0);
        check("t1_ack_count", a0cnt - s_a0, 1);
        check("t1_no_ack1", a1cnt - s_a1, 0);

        // 2: req1 read after reset
        do_reset();
        snap();
        drive1(1'b1, 1'b0, 8'h14, 16'h0000);
        wait_ack(1, 40, cyc);
        drive1(1'b0, 1'b0, 8'h00, 16'h0000);
        check("t2_latency", cyc, 3);
        check("t2_rstrobe", rcnt - s_r, 1);
        check("t2_wstrobe", wcnt - s_w, 0);
        check("t2_grant", strobe_grant, 2'b10);
        check("t2_rdata", req1_rdata, 16'h0000);
        check("t2_error", req1_error, 1'b0);
        step();
        check("t2_no_ack0", a0cnt - s_a0, 0);

        // 3: both valid from reset, req0 first, then req1
        do_reset();
        snap();
        drive0(1'b1, 1'b1, 8'h12, 16'h0005);
        drive1(1'b1, 1'b0, 8'h12, 16'h0000);
        wait_ack(0, 40, cyc);
        drive0(1'b0, 1'b0, 8'h00, 16'h0000);
        check("t3_req0_first", cyc, 3);
        check("t3_req0_grant", strobe_grant, 2'b01);
        check("t3_req1_waits", req1_ack, 1'b0);
        wait_ack(1, 40, cyc);
        drive1(1'b0, 1'b0, 8'h00, 16'h0000);
        check("t3_req1_latency", cyc, 3);
        check("t3_req1_grant", strobe_grant, 2'b10);
        check("t3_req1_rdata", req1_rdata, 16'h0005);
        step();
        // both again: pointer now points away from req1
        snap();
        drive0(1'b1, 1'b0, 8'h12, 16'h0000);
        drive1(1'b1, 1'b1, 8'h13, 16'h0007);
        wait_ack(0, 40, cyc);
        drive0(1'b0, 1'b0, 8'h00, 16'h0000);
        check("t3b_req0_first", cyc, 3);
        check("t3b_req0_rdata", req0_rdata, 16'h0005);
        check("t3b_req1_not_yet", a1cnt - s_a1, 0);
        wait_ack(1, 40, cyc);
        drive1(1'b0, 1'b0, 8'h00, 16'h0000);
        check("t3b_req1_latency", cyc, 3);
        check("t3b_req1_wr_rdata", req1_rdata, 16'h0000);
        check("t3b_req0_rdata_hold", req0_rdata, 16'h0005);
        check("t3b_mem13", mem[8'h13], 16'h0007);
        step();

        // 4: invalid address read
        drive0(1'b1, 1'b0, 8'h33, 16'h0000);
        wait_ack(0, 40, cyc);
        drive0(1'b0, 1'b0, 8'h00, 16'h0000);
        check("t4_latency", cyc, 3);
        check("t4_error", req0_error, 1'b1);
        check("t4_rdata", req0_rdata, 16'h0000);
        step();

        // rf_done/rf_error while idle must be ignored
        snap();
        force_done = 1'b1; force_err = 1'b1;
        step();
        force_done = 1'b0; force_err = 1'b0;
        step();
        check("idle_done_busy", busy, 1'b0);
        check("idle_done_acks", (a0cnt - s_a0) + (a1cnt - s_a1), 0);
        check("idle_done_err1_hold", req1_error, 1'b0);

        // normal read afterwards restores a clean req0 response
        drive0(1'b1, 1'b0, 8'h12, 16'h0000);
        wait_ack(0, 40, cyc);
        drive0(1'b0, 1'b0, 8'h00, 16'h0000);
        check("post_idle_latency", cyc, 3);
        check("post_idle_rdata", req0_rdata, 16'h0005);
        check("post_idle_error", req0_error, 1'b0);
        step();

        // 5: regfile never answers -> timeout
        stub_en = 1'b0;
        snap();
        drive0(1'b1, 1'b0, 8'h12, 16'h0000);
        wait_ack(0, 40, cyc);
        drive0(1'b0, 1'b0, 8'h00, 16'h0000);
        check("t5_latency", cyc, 17);
        check("t5_error", req0_error, 1'b1);
        check("t5_rdata", req0_rdata, 16'h0000);
        check("t5_busy_at_ack", busy, 1'b0);
        check("t5_busy_cycles", bcnt - s_b, 16);
        step();

        // 6: reset in the middle of WAIT
        drive0(1'b1, 1'b1, 8'h11, 16'h0009);
        step();
        step();
        step();
        check("t6_busy_before", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_ctrl", {busy, grant, rf_read, rf_write, req0_ack, req0_error}, 0);
        check("t6_async_addr", rf_addr, 8'h00);
        drive0(1'b0, 1'b0, 8'h00, 16'h0000);
        step();
        rst_n = 1'b1;
        snap();
        for (int k = 0; k < 20; k++) step();
        check("t6_no_ack", a0cnt - s_a0, 0);
        stub_en = 1'b1;
        drive0(1'b1, 1'b1, 8'h11, 16'h0009);
        wait_ack(0, 40, cyc);
        drive0(1'b0, 1'b0, 8'h00, 16'h0000);
        check("t6_retry_latency", cyc, 3);
        check("t6_retry_error", req0_error, 1'b0);
        check("t6_retry_mem", mem[8'h11], 16'h0009);
        step();

        check("never_both_strobes", bothcnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
